// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared types and the round-robin pick function for mux4_rr_arbiter.
// Contents: NUM_REQ and IDX_W, the state_t enum {IDLE, GRANT}, the pick_t result struct,
// and rr_pick(req, ptr), which returns the first asserted request searching upward
// from ptr+1 (mod NUM_REQ).
package mux4_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // The candidate index wraps modulo NUM_REQ, so the last candidate checked is ptr itself.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester-side bus of the shared 4:1 mux lane.
// Signals:
//   REQ[3:0]      request, one bit per requester (level-sensitive)
//   A0..A3[W-1:0] requester data
//   LOCK[3:0]     quantum override per requester; present only with MUX4_ARB_LOCK_EN
//   GNT[3:0]      registered one-hot grant
//   SL0, SL1      registered lane select
//   Z[W-1:0]      registered true-polarity data from the granted requester
//   ZV            Z valid
// Modports: slave is the arbiter side; master is the requester side.
interface mux4_rr_arbiter_if
    import mux4_arb_pkg::*;
#(
    parameter int unsigned W = 8
);
    logic [NUM_REQ-1:0] REQ;
    logic [W-1:0]       A0;
    logic [W-1:0]       A1;
    logic [W-1:0]       A2;
    logic [W-1:0]       A3;
`ifdef MUX4_ARB_LOCK_EN
    logic [NUM_REQ-1:0] LOCK;
`endif
    logic [NUM_REQ-1:0] GNT;
    logic               SL0;
    logic               SL1;
    logic [W-1:0]       Z;
    logic               ZV;

`ifdef MUX4_ARB_LOCK_EN
    modport slave  (input  REQ, A0, A1, A2, A3, LOCK, output GNT, SL0, SL1, Z, ZV);
    modport master (output REQ, A0, A1, A2, A3, LOCK, input  GNT, SL0, SL1, Z, ZV);
`else
    modport slave  (input  REQ, A0, A1, A2, A3, output GNT, SL0, SL1, Z, ZV);
    modport master (output REQ, A0, A1, A2, A3, input  GNT, SL0, SL1, Z, ZV);
`endif

endinterface

// File: rtl/HDMUXB4D2.sv
// HDMUXB4D2: behavioral model of the inverting 4:1 mux library cell.
// Ports: A0..A3 data in; SL0, SL1 select in ({SL1,SL0} is the index); Z = ~A[{SL1,SL0}] out.
module HDMUXB4D2 (
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic SL0,
    input  logic SL1,
    output logic Z
);
    always_comb begin
        Z = 1'b1;
        case ({SL1, SL0})
            2'd0: Z = ~A0;
            2'd1: Z = ~A1;
            2'd2: Z = ~A2;
            2'd3: Z = ~A3;
            default: Z = 1'b1;
        endcase
    end
endmodule

// File: rtl/mux4_inv_lane.sv
// mux4_inv_lane: W-bit inverting 4:1 mux lane built from HDMUXB4D2 cells that share one select pair.
// Ports: a0..a3[W-1:0] data in; sl0, sl1 select in; zn_c[W-1:0] = ~a[{sl1,sl0}] (combinational).
module mux4_inv_lane #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    input  logic         sl0,
    input  logic         sl1,
    output logic [W-1:0] zn_c
);
    for (genvar i = 0; i < int'(W); i++) begin : g_bit
        HDMUXB4D2 u_cell (
            .A0  (a0[i]),
            .A1  (a1[i]),
            .A2  (a2[i]),
            .A3  (a3[i]),
            .SL0 (sl0),
            .SL1 (sl1),
            .Z   (zn_c[i])
        );
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that shares one inverting 4:1 mux lane among four
// requesters. A per-grant quantum stops any requester holding the lane indefinitely while
// others wait. The lane output is re-inverted and registered as Z with the valid strobe ZV.
// Ports: CK clock; RN asynchronous active-low reset; bus (mux4_rr_arbiter_if.slave) carries
//        REQ, A0..A3, [LOCK], GNT, SL0, SL1, Z, ZV.
// Parameters: W data width; QUANTUM is the most consecutive grant cycles allowed while
//             another request is pending (must be >= 1).
// Option: MUX4_ARB_LOCK_EN adds LOCK. While LOCK[g] is high for the current grantee g, the
//         quantum cannot expire.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned QUANTUM = 4
) (
    input  logic              CK,
    input  logic              RN,
    mux4_rr_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(QUANTUM + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [W-1:0]       z_q;
    logic               zv_q;

    logic [W-1:0]       lane_zn_c;
    logic [NUM_REQ-1:0] others_c;
    logic               cnt_at_last_c;
    logic               hold_c;
    logic               expire_c;
    logic               release_c;
    pick_t              idle_pick_c;
    pick_t              next_pick_c;

    // Shared inverting lane, steered only by the registered select.
    mux4_inv_lane #(.W(W)) u_lane (
        .a0   (bus.A0),
        .a1   (bus.A1),
        .a2   (bus.A2),
        .a3   (bus.A3),
        .sl0  (sel_q[0]),
        .sl1  (sel_q[1]),
        .zn_c (lane_zn_c)
    );

    // Release decision. While in GRANT, sel_q always holds the grantee index.
    always_comb begin
        others_c      = bus.REQ & ~(NUM_REQ'(1) << sel_q);
        cnt_at_last_c = (cnt_q == CNT_LAST);
`ifdef MUX4_ARB_LOCK_EN
        hold_c        = bus.LOCK[sel_q];
`else
        hold_c        = 1'b0;
`endif
        expire_c      = cnt_at_last_c && (|others_c) && !hold_c;
        release_c     = !bus.REQ[sel_q] || expire_c;
        idle_pick_c   = rr_pick(bus.REQ, ptr_q);
        // On either kind of release, the grantee is excluded from the next pick.
        next_pick_c   = rr_pick(others_c, sel_q);
    end

    // Grant FSM and output data register.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            z_q     <= '0;
            zv_q    <= 1'b0;
        end else begin
            zv_q <= (state_q == GRANT);
            if (state_q == GRANT) begin
                z_q <= ~lane_zn_c;
            end
            case (state_q)
                IDLE: begin
                    if (idle_pick_c.found) begin
                        state_q <= GRANT;
                        sel_q   <= idle_pick_c.idx;
                        gnt_q   <= NUM_REQ'(1) << idle_pick_c.idx;
                        cnt_q   <= '0;
                    end else begin
                        gnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        ptr_q <= sel_q;
                        if (next_pick_c.found) begin
                            sel_q <= next_pick_c.idx;
                            gnt_q <= NUM_REQ'(1) << next_pick_c.idx;
                            cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else if (!cnt_at_last_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.GNT = gnt_q;
    assign bus.SL0 = sel_q[0];
    assign bus.SL1 = sel_q[1];
    assign bus.Z   = z_q;
    assign bus.ZV  = zv_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench for mux4_rr_arbiter (W=8, QUANTUM=4).
// Each stimulus cycle queues the hand-derived outputs expected after the next rising edge.
// A monitor on the falling edge pops and compares them. The LOCK sequence runs only when
// MUX4_ARB_LOCK_EN is defined.
module tb_mux4_rr_arbiter;
    import mux4_arb_pkg::*;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       zv;
        logic [7:0] z;
    } exp_t;

    logic ck = 1'b0;
    logic rn = 1'b0;
    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] dat [4];

    mux4_rr_arbiter_if #(.W(8)) bus ();

    mux4_rr_arbiter #(.W(8), .QUANTUM(4)) dut (
        .CK  (ck),
        .RN  (rn),
        .bus (bus.slave)
    );

    always #5 ck = ~ck;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, want, $time);
        end
    endfunction

    // Monitor: compares DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge ck);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt", 32'(bus.GNT), 32'(e.gnt));
                chk("sel", 32'({bus.SL1, bus.SL0}), 32'(e.sel));
                chk("zv",  32'(bus.ZV), 32'(e.zv));
                chk("z",   32'(bus.Z), 32'(e.z));
            end
        end
    end

    // Drive REQ for one cycle and queue the outputs expected after that edge.
    task automatic cyc(input logic [3:0] req, input logic [3:0] eg, input logic [1:0] es,
                       input logic ezv, input logic [7:0] ez);
        exp_t e;
        bus.REQ = req;
        e.gnt = eg;
        e.sel = es;
        e.zv  = ezv;
        e.z   = ez;
        q.push_back(e);
        @(negedge ck);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         idx;
        int         pidx;
        logic [7:0] zval;
        dat[0] = 8'h11;
        dat[1] = 8'h3C;
        dat[2] = 8'h5A;
        dat[3] = 8'hC3;
        bus.A0  = dat[0];
        bus.A1  = dat[1];
        bus.A2  = dat[2];
        bus.A3  = dat[3];
        bus.REQ = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
        bus.LOCK = 4'b0000;
`endif
        @(negedge ck);
        #1;

        // Reset state, then first grant to requester 1 and its data two cycles later.
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00);
        rn = 1'b1;
        cyc(4'b0110, 4'b0010, 2'd1, 1'b0, 8'h00);
        cyc(4'b0110, 4'b0010, 2'd1, 1'b1, 8'h3C);
        cyc(4'b0000, 4'b0000, 2'd1, 1'b1, 8'h3C);
        cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 8'h3C);

        // Full contention from PTR=1: order 2,3,0,1,2, four cycles each, ZV unbroken.
        for (int k = 0; k < 17; k++) begin
            idx  = (2 + k / 4) % 4;
            pidx = (k == 0) ? 0 : (2 + (k - 1) / 4) % 4;
            zval = (k == 0) ? 8'h3C : dat[pidx];
            cyc(4'b1111, 4'(1) << idx, 2'(idx), (k > 0), zval);
        end

        // Lone requester 2 keeps the grant well past the quantum.
        for (int k = 0; k < 20; k++) begin
            cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 8'h5A);
        end

        // Grantee 2 drops with REQ[0] pending: back-to-back grant to 0, then idle with Z held.
        cyc(4'b0001, 4'b0001, 2'd0, 1'b1, 8'h5A);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b1, 8'h11);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 8'h11);
        // PTR=0, so requester 1 wins over requester 3.
        cyc(4'b1010, 4'b0010, 2'd1, 1'b0, 8'h11);
        cyc(4'b0000, 4'b0000, 2'd1, 1'b1, 8'h3C);

        // Asynchronous reset in the middle of a grant.
        cyc(4'b0001, 4'b0001, 2'd0, 1'b0, 8'h3C);
        cyc(4'b0001, 4'b0001, 2'd0, 1'b1, 8'h11);
        rn = 1'b0;
        #1;
        chk("async_gnt", 32'(bus.GNT), 32'h0);
        chk("async_sel", 32'({bus.SL1, bus.SL0}), 32'h0);
        chk("async_zv",  32'(bus.ZV), 32'h0);
        chk("async_z",   32'(bus.Z), 32'h0);
        cyc(4'b1000, 4'b0000, 2'd0, 1'b0, 8'h00);
        rn = 1'b1;
        cyc(4'b1000, 4'b1000, 2'd3, 1'b0, 8'h00);
        cyc(4'b0000, 4'b0000, 2'd3, 1'b1, 8'hC3);
        cyc(4'b0000, 4'b0000, 2'd3, 1'b0, 8'hC3);

        // Grantee 0 drops REQ in the same cycle its quantum expires.
        cyc(4'b0011, 4'b0001, 2'd0, 1'b0, 8'hC3);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0011, 4'b0001, 2'd0, 1'b1, 8'h11);
        end
        cyc(4'b0010, 4'b0010, 2'd1, 1'b1, 8'h11);
        cyc(4'b0000, 4'b0000, 2'd1, 1'b1, 8'h3C);

`ifdef MUX4_ARB_LOCK_EN
        // LOCK[0] holds the grant past the quantum; dropping it releases at once.
        bus.LOCK = 4'b0001;
        cyc(4'b0011, 4'b0001, 2'd0, 1'b0, 8'h3C);
        for (int k = 0; k < 6; k++) begin
            cyc(4'b0011, 4'b0001, 2'd0, 1'b1, 8'h11);
        end
        bus.LOCK = 4'b0000;
        cyc(4'b0011, 4'b0010, 2'd1, 1'b1, 8'h11);
        cyc(4'b0000, 4'b0000, 2'd1, 1'b1, 8'h3C);
`endif

        chk("queue_drain", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
